// File: rtl/fp_mul_exp_adjust.sv
// Exponent stage of the FP multiplier: removes the bias, flags overflow/underflow, two-stage elastic pipeline.
// Optional sticky overflow/underflow flags are enabled by defining FPM_EXP_STICKY_FLAGS_EN.
module fp_mul_exp_adjust #(
    parameter int EW   = 11,
    parameter int BIAS = 1023
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [EW:0]   exp_sum,
    input  logic          norm_inc,
    input  logic          zero_in,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [EW-1:0] exp_out,
    output logic          ovf,
    output logic          unf
`ifdef FPM_EXP_STICKY_FLAGS_EN
    ,
    input  logic          clr_flags,
    output logic          ovf_sticky,
    output logic          unf_sticky
`endif
);

    localparam logic signed [EW+1:0] BIAS_S = (EW+2)'(BIAS);
    localparam logic signed [EW+1:0] MAX_S  = (EW+2)'((1 << EW) - 1);

    // Returns {exponent, ovf, unf} for one beat; zero operands override any range check.
    function automatic logic [EW+1:0] adjust(input logic [EW:0] sum, input logic inc, input logic zero);
        logic signed [EW+1:0] r;
        r = $signed({1'b0, sum}) + $signed({{(EW+1){1'b0}}, inc}) - BIAS_S;
        if (zero)
            adjust = '0;
        else if (r >= MAX_S)
            adjust = {{EW{1'b1}}, 2'b10};
        else if (r <= 0)
            adjust = {{EW{1'b0}}, 2'b01};
        else
            adjust = {r[EW-1:0], 2'b00};
    endfunction

    logic          vld_p1_q, vld_p1_d;
    logic [EW:0]   sum_p1_q, sum_p1_d;
    logic          inc_p1_q, inc_p1_d;
    logic          zero_p1_q, zero_p1_d;
    logic          vld_p2_q, vld_p2_d;
    logic [EW-1:0] exp_p2_q, exp_p2_d;
    logic          ovf_p2_q, ovf_p2_d;
    logic          unf_p2_q, unf_p2_d;
    logic          s1_en, s2_en;

    always_comb begin
        s2_en     = !vld_p2_q || out_ready;
        s1_en     = !vld_p1_q || s2_en;
        in_ready  = s1_en;

        // Stage 1: capture the raw operands
        vld_p1_d  = s1_en ? in_valid : vld_p1_q;
        sum_p1_d  = sum_p1_q;
        inc_p1_d  = inc_p1_q;
        zero_p1_d = zero_p1_q;
        if (s1_en && in_valid) begin
            sum_p1_d  = exp_sum;
            inc_p1_d  = norm_inc;
            zero_p1_d = zero_in;
        end

        // Stage 2: bias removal and range classification
        vld_p2_d  = s2_en ? vld_p1_q : vld_p2_q;
        exp_p2_d  = exp_p2_q;
        ovf_p2_d  = ovf_p2_q;
        unf_p2_d  = unf_p2_q;
        if (s2_en && vld_p1_q)
            {exp_p2_d, ovf_p2_d, unf_p2_d} = adjust(sum_p1_q, inc_p1_q, zero_p1_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1_q <= 1'b0;
            vld_p2_q <= 1'b0;
            exp_p2_q <= '0;
            ovf_p2_q <= 1'b0;
            unf_p2_q <= 1'b0;
        end else begin
            vld_p1_q <= vld_p1_d;
            vld_p2_q <= vld_p2_d;
            exp_p2_q <= exp_p2_d;
            ovf_p2_q <= ovf_p2_d;
            unf_p2_q <= unf_p2_d;
        end
    end

    // Stage-1 payload is qualified by vld_p1_q, so it needs no reset.
    always_ff @(posedge clk) begin
        sum_p1_q  <= sum_p1_d;
        inc_p1_q  <= inc_p1_d;
        zero_p1_q <= zero_p1_d;
    end

    assign out_valid = vld_p2_q;
    assign exp_out   = exp_p2_q;
    assign ovf       = ovf_p2_q;
    assign unf       = unf_p2_q;

`ifdef FPM_EXP_STICKY_FLAGS_EN
    logic ovf_sticky_q, ovf_sticky_d;
    logic unf_sticky_q, unf_sticky_d;
    logic out_fire;

    // A flag-carrying transfer wins over a coincident clear.
    always_comb begin
        out_fire     = vld_p2_q && out_ready;
        ovf_sticky_d = clr_flags ? 1'b0 : ovf_sticky_q;
        unf_sticky_d = clr_flags ? 1'b0 : unf_sticky_q;
        if (out_fire && ovf_p2_q) ovf_sticky_d = 1'b1;
        if (out_fire && unf_p2_q) unf_sticky_d = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_sticky_q <= 1'b0;
            unf_sticky_q <= 1'b0;
        end else begin
            ovf_sticky_q <= ovf_sticky_d;
            unf_sticky_q <= unf_sticky_d;
        end
    end

    assign ovf_sticky = ovf_sticky_q;
    assign unf_sticky = unf_sticky_q;
`endif

endmodule

// File: tb/tb_fp_mul_exp_adjust.sv
// Bench for fp_mul_exp_adjust: directed vectors, backpressure, reset, and randomized scoreboard run.
module tb_fp_mul_exp_adjust;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [11:0] exp_sum = '0;
    logic        norm_inc = 1'b0;
    logic        zero_in = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [10:0] exp_out;
    logic        ovf;
    logic        unf;
`ifdef FPM_EXP_STICKY_FLAGS_EN
    logic        clr_flags = 1'b0;
    logic        ovf_sticky;
    logic        unf_sticky;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fp_mul_exp_adjust #(.EW(11), .BIAS(1023)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .exp_sum(exp_sum), .norm_inc(norm_inc), .zero_in(zero_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .exp_out(exp_out), .ovf(ovf), .unf(unf)
`ifdef FPM_EXP_STICKY_FLAGS_EN
        , .clr_flags(clr_flags), .ovf_sticky(ovf_sticky), .unf_sticky(unf_sticky)
`endif
    );

    // Reference: unbiased exponent as plain integer, then classify.
    function automatic logic [12:0] ref_model(input int sum, input int inc, input int zero);
        int r;
        logic [10:0] e;
        r = sum + inc - 1023;
        if (zero != 0) return 13'd0;
        if (r >= 2047) return {11'h7FF, 2'b10};
        if (r <= 0) return {11'd0, 2'b01};
        e = r[10:0];
        return {e, 2'b00};
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b1;
        exp_sum = 12'd2046;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if ({out_valid, exp_out, ovf, unf} !== 14'd0) begin
            errors++;
            $display("FAIL reset_outputs got valid=%0b exp=%0d ovf=%0b unf=%0b want all 0", out_valid, exp_out, ovf, unf);
        end
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready got %0b want 1", in_ready);
        end
    endtask

    task automatic test_directed();
        int sums  [9] = '{2046, 2046, 3070, 1000, 1023, 1023, 4000, 3069, 4095};
        int incs  [9] = '{0, 1, 0, 0, 0, 1, 0, 0, 1};
        int zeros [9] = '{0, 0, 0, 0, 0, 0, 1, 0, 0};
        logic [12:0] want [9] = '{{11'd1023, 2'b00}, {11'd1024, 2'b00}, {11'd2047, 2'b10},
                                  {11'd0, 2'b01}, {11'd0, 2'b01}, {11'd1, 2'b00},
                                  {11'd0, 2'b00}, {11'd2046, 2'b00}, {11'd2047, 2'b10}};
        @(negedge clk);
        out_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            in_valid = 1'b1;
            exp_sum  = 12'(sums[i]);
            norm_inc = incs[i][0];
            zero_in  = zeros[i][0];
            #1;
            checks++;
            if (in_ready !== 1'b1) begin
                errors++;
                $display("FAIL dir%0d_in_ready got %0b want 1", i, in_ready);
            end
            @(posedge clk);
            @(negedge clk);
            in_valid = 1'b0;
            #1;
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL dir%0d_latency1 out_valid got %0b want 0", i, out_valid);
            end
            @(negedge clk);
            #1;
            checks++;
            if (out_valid !== 1'b1 || {exp_out, ovf, unf} !== want[i]) begin
                errors++;
                $display("FAIL dir%0d_result sum=%0d inc=%0d zero=%0d got v=%0b exp=%0d ovf=%0b unf=%0b want exp=%0d ovf=%0b unf=%0b",
                         i, sums[i], incs[i], zeros[i], out_valid, exp_out, ovf, unf,
                         want[i][12:2], want[i][1], want[i][0]);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        int sums [3] = '{2046, 1000, 3070};
        logic [12:0] want [3];
        int idx;
        logic c_taken;
        for (int i = 0; i < 3; i++) want[i] = ref_model(sums[i], 0, 0);
        @(negedge clk);
        out_ready = 1'b0;
        norm_inc = 1'b0;
        zero_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            exp_sum  = 12'(sums[i]);
            #1;
            checks++;
            if (in_ready !== (i < 2)) begin
                errors++;
                $display("FAIL bp_in_ready_beat%0d got %0b want %0b", i, in_ready, i < 2);
            end
            if (i < 2) @(negedge clk);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1;
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || {exp_out, ovf, unf} !== want[0]) begin
                errors++;
                $display("FAIL bp_stall%0d got rdy=%0b v=%0b exp=%0d ovf=%0b unf=%0b want rdy=0 v=1 exp=%0d",
                         k, in_ready, out_valid, exp_out, ovf, unf, want[0][12:2]);
            end
        end
        out_ready = 1'b1;
        #1;
        idx = 0;
        c_taken = 1'b0;
        for (int cyc = 0; cyc < 12 && idx < 3; cyc++) begin
            if (in_valid && in_ready) c_taken = 1'b1;
            if (out_valid && out_ready) begin
                checks++;
                if ({exp_out, ovf, unf} !== want[idx]) begin
                    errors++;
                    $display("FAIL bp_order%0d got exp=%0d ovf=%0b unf=%0b want exp=%0d ovf=%0b unf=%0b",
                             idx, exp_out, ovf, unf, want[idx][12:2], want[idx][1], want[idx][0]);
                end
                idx++;
            end
            @(negedge clk);
            if (c_taken) in_valid = 1'b0;
            #1;
        end
        in_valid = 1'b0;
        checks++;
        if (idx != 3) begin
            errors++;
            $display("FAIL bp_count got %0d beats want 3", idx);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_midflight();
        logic stale;
        @(negedge clk);
        out_ready = 1'b0;
        in_valid = 1'b1;
        exp_sum = 12'd2500;
        @(negedge clk);
        exp_sum = 12'd2600;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_full got v=%0b rdy=%0b want v=1 rdy=0", out_valid, in_ready);
        end
        rst = 1'b1;
        in_valid = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || exp_out !== 11'd0) begin
            errors++;
            $display("FAIL rst_mid_async got v=%0b exp=%0d want v=0 exp=0", out_valid, exp_out);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        stale = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1;
            if (out_valid !== 1'b0) stale = 1'b1;
            @(negedge clk);
        end
        checks++;
        if (stale !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_stale got a beat after reset want none");
        end
    endtask

    task automatic test_random();
        logic [12:0] q[$];
        logic [12:0] prev;
        logic [12:0] got;
        logic stalled;
        int s, inc, z;
        stalled = 1'b0;
        prev = '0;
        @(negedge clk);
        for (int cyc = 0; cyc < 600; cyc++) begin
            s   = ($urandom_range(0, 1) != 0) ? int'($urandom_range(900, 3200)) : int'($urandom_range(0, 4095));
            inc = int'($urandom_range(0, 1));
            z   = ($urandom_range(0, 7) == 0) ? 1 : 0;
            in_valid  = (cyc < 580) && ($urandom_range(0, 3) != 0);
            exp_sum   = 12'(s);
            norm_inc  = inc[0];
            zero_in   = z[0];
            out_ready = (cyc >= 580) || ($urandom_range(0, 2) != 0);
            #1;
            got = {exp_out, ovf, unf};
            if (stalled) begin
                checks++;
                if (out_valid !== 1'b1 || got !== prev) begin
                    errors++;
                    $display("FAIL rnd_hold cyc=%0d got v=%0b data=%h want v=1 data=%h", cyc, out_valid, got, prev);
                end
            end
            if (out_valid && out_ready) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL rnd_spurious cyc=%0d got data=%h want no beat", cyc, got);
                end else if (got !== q[0]) begin
                    errors++;
                    $display("FAIL rnd_data cyc=%0d got %h want %h", cyc, got, q[0]);
                    void'(q.pop_front());
                end else begin
                    void'(q.pop_front());
                end
            end
            if (in_valid && in_ready) q.push_back(ref_model(s, inc, z));
            stalled = out_valid && !out_ready;
            prev = got;
            @(negedge clk);
        end
        in_valid = 1'b0;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL rnd_drain got %0d beats left want 0", q.size());
        end
    endtask

`ifdef FPM_EXP_STICKY_FLAGS_EN
    task automatic test_sticky();
        @(negedge clk);
        out_ready = 1'b1;
        clr_flags = 1'b0;
        in_valid = 1'b1;
        exp_sum = 12'd3070;
        norm_inc = 1'b0;
        zero_in = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        #1;
        checks++;
        if (ovf_sticky !== 1'b1 || unf_sticky !== 1'b0) begin
            errors++;
            $display("FAIL sticky_set got ovf_s=%0b unf_s=%0b want 1 0", ovf_sticky, unf_sticky);
        end
        clr_flags = 1'b1;
        @(negedge clk);
        clr_flags = 1'b0;
        #1;
        checks++;
        if (ovf_sticky !== 1'b0) begin
            errors++;
            $display("FAIL sticky_clear got %0b want 0", ovf_sticky);
        end
        in_valid = 1'b1;
        exp_sum = 12'd3500;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        clr_flags = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b1 || ovf !== 1'b1) begin
            errors++;
            $display("FAIL sticky_align got v=%0b ovf=%0b want 1 1", out_valid, ovf);
        end
        @(negedge clk);
        clr_flags = 1'b0;
        #1;
        checks++;
        if (ovf_sticky !== 1'b1) begin
            errors++;
            $display("FAIL sticky_set_wins got %0b want 1", ovf_sticky);
        end
        in_valid = 1'b1;
        exp_sum = 12'd500;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (unf_sticky !== 1'b1) begin
            errors++;
            $display("FAIL sticky_unf got %0b want 1", unf_sticky);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_random();
        test_reset_midflight();
`ifdef FPM_EXP_STICKY_FLAGS_EN
        test_sticky();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
